// File: rtl/iter_div_unit.sv
// iter_div_unit -- multi-cycle radix-2 restoring divider for DIV/DIVU.
//
// A start pulse captures the operand magnitudes. The unit then produces one
// quotient bit per clock and writes the quotient to lo and the remainder to hi.
// While an operation is in flight, stall holds the pipeline.
//
// Configuration macro: DIV_SIGNED_EN
//   defined   : is_signed selects DIV (two's complement) or DIVU
//   undefined : every operation is unsigned and is_signed is ignored
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        divide request, sampled only in IDLE or DONE
//   is_signed    1 = DIV, 0 = DIVU
//   a, b         dividend, divisor
//   flush        abort the in-flight operation; also rejects a same-cycle start
//   stall        combinational: start accepted or BUSY
//   done         one-cycle pulse after hi/lo receive a new result
//   div_by_zero  valid with done: divisor was zero
//   hi, lo       remainder / quotient result registers
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no operation; hi/lo hold the last result
// BUSY  | iterating, one quotient bit per edge
// DONE  | result just written (done=1); a new start may be accepted
module iter_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd, rem, dsr;
   logic             start_acc, last_iter, rem_ge;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_nxt, dvd_nxt, a_mag, b_mag, q_fix, r_fix;

   assign start_acc = start & (state != S_BUSY) & ~flush;
   assign stall     = start_acc | (state == S_BUSY);
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));

   // Keep the shifted-out remainder MSB so the compare never loses a carry.
   // The difference always fits in WIDTH bits because it is below the divisor.
   assign rem_sh  = {rem, dvd[WIDTH-1]};
   assign rem_ge  = (rem_sh >= {1'b0, dsr});
   assign rem_nxt = rem_ge ? (rem_sh[WIDTH-1:0] - dsr) : rem_sh[WIDTH-1:0];
   assign dvd_nxt = {dvd[WIDTH-2:0], rem_ge};

`ifdef DIV_SIGNED_EN
   logic a_neg, b_neg, q_neg, r_neg;

   assign a_neg = is_signed & a[WIDTH-1];
   assign b_neg = is_signed & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;
   assign q_fix = q_neg ? -dvd_nxt : dvd_nxt;
   assign r_fix = r_neg ? -rem_nxt : rem_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (start_acc) begin
         q_neg <= a_neg ^ b_neg;
         r_neg <= a_neg;
      end
   end
`else
   logic sig_unused;

   assign sig_unused = is_signed;
   assign a_mag      = a;
   assign b_mag      = b;
   assign q_fix      = dvd_nxt;
   assign r_fix      = rem_nxt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (start_acc) state_nxt = (b == '0) ? S_DONE : S_BUSY;
         S_BUSY: if (last_iter) state_nxt = S_DONE;
         S_DONE: begin
            if (start_acc) state_nxt = (b == '0) ? S_DONE : S_BUSY;
            else           state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         dvd         <= '0;
         rem         <= '0;
         dsr         <= '0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         if (start_acc) begin
            cnt <= '0;
            dvd <= a_mag;
            rem <= '0;
            dsr <= b_mag;
            if (b == '0) begin
               lo          <= '1;
               hi          <= a;
               done        <= 1'b1;
               div_by_zero <= 1'b1;
            end
         end else if (state == S_BUSY && !flush) begin
            cnt <= cnt + 1'b1;
            dvd <= dvd_nxt;
            rem <= rem_nxt;
            // The last step's bits go straight into the fix-up.
            if (last_iter) begin
               lo   <= q_fix;
               hi   <= r_fix;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_iter_div_unit.sv
module tb_iter_div_unit;
   localparam int W = 32;
`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         is_signed = 1'b0;
   logic         flush = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         stall, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;

   iter_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
      .a(a), .b(b), .flush(flush), .stall(stall), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic on 64-bit signed values (truncating division).
   function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
      longint sx, sy;
      if (y == '0) begin
         q = '1;
         r = x;
      end else if (sgn) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         q  = W'(sx / sy);
         r  = W'(sx % sy);
      end else begin
         q = x / y;
         r = x % y;
      end
   endfunction

   // Called between a negedge and the following posedge; returns at negedge+1
   // of the done cycle with start already deasserted.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn, input bit noise);
      logic [W-1:0] eq, er;
      int  st_cnt, cyc, exp_cyc;
      bit  seen;
      ref_div(x, y, sgn & SIGNED_EN, eq, er);
      exp_cyc = (y == '0) ? 1 : W + 1;
      a = x; b = y; is_signed = sgn; start = 1'b1;
      #1;
      check_val("stall_on_accept", W'(stall), W'(1));
      st_cnt = stall ? 1 : 0;
      seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < 45) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         #1;
         if (done) seen = 1'b1;
         else begin
            if (stall) st_cnt++;
            if (noise && $urandom_range(0, 3) == 0) begin
               start = 1'b1; a = $urandom; b = $urandom; is_signed = 1'($urandom);
            end
         end
      end
      check_val("done_seen", W'(seen), W'(1));
      if (seen) begin
         check_val("done_latency", W'(cyc), W'(exp_cyc));
         check_val("stall_cycles", W'(st_cnt), W'(exp_cyc));
         check_val("lo", lo, eq);
         check_val("hi", hi, er);
         check_val("div_by_zero", W'(div_by_zero), W'(y == '0));
      end
   endtask

   initial begin
      logic [W-1:0] x, y, plo, phi;
      int ndone;
      #1;
      check_val("rst_hi", hi, '0);
      check_val("rst_lo", lo, '0);
      check_val("rst_done", W'(done), '0);
      check_val("rst_dbz", W'(div_by_zero), '0);
      check_val("rst_stall", W'(stall), '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;

      run_op(32'd100, 32'd7, 1'b0, 1'b0);
      @(negedge clk); #1;
      check_val("done_pulse_low", W'(done), '0);
      check_val("idle_stall", W'(stall), '0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op(32'd5, 32'd0, 1'b0, 1'b0);
      @(negedge clk); #1;

      // Flush in the middle of an operation.
      run_op(32'd100, 32'd7, 1'b0, 1'b0);
      plo = lo; phi = hi;
      a = 32'd1000; b = 32'd3; start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check_val("flush_idle_stall", W'(stall), '0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (done) ndone++;
      end
      check_val("flush_no_done", W'(ndone), '0);
      check_val("flush_keep_lo", lo, plo);
      check_val("flush_keep_hi", hi, phi);
      run_op(32'd1000, 32'd3, 1'b0, 1'b0);

      // Back-to-back start in the done cycle, with start noise while busy.
      run_op(32'd100, 32'd7, 1'b0, 1'b1);
      run_op(32'd9, 32'd4, 1'b0, 1'b1);
      plo = lo; phi = hi;

      // Flush rejects a start in the done cycle.
      a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
      #1;
      check_val("flush_start_stall", W'(stall), '0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check_val("flush_start_done", W'(done), '0);
      check_val("flush_start_stall2", W'(stall), '0);
      check_val("flush_start_lo", lo, plo);
      check_val("flush_start_hi", hi, phi);

      // Randomized operations, some chained back-to-back.
      for (int i = 0; i < 40; i++) begin
         bit chain;
         x = $urandom;
         if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
         case ($urandom_range(0, 3))
            0:       y = '0;
            1:       y = W'($urandom_range(1, 15));
            2:       y = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
            default: y = $urandom;
         endcase
         chain = 1'($urandom_range(0, 1));
         run_op(x, y, 1'($urandom), 1'($urandom));
         if (!chain) begin
            @(negedge clk); #1;
            check_val("rand_done_low", W'(done), '0);
         end
      end

      // Asynchronous reset between clock edges while busy.
      @(negedge clk); #1;
      a = 32'd100; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("arst_hi", hi, '0);
      check_val("arst_lo", lo, '0);
      check_val("arst_done", W'(done), '0);
      check_val("arst_stall", W'(stall), '0);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      check_val("arst_idle_stall", W'(stall), '0);
      run_op(32'd9, 32'd4, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
